// File: rtl/multicycle_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu_if
// Brief    : Request/result bundle between a requester and multicycle_alu.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       ALUOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Jr;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             DivByZero;

  // Requester side: issues operations, observes results.
  modport master (
    output Start, ALUOperation, A, B,
    input  Busy, Done, ALUResult, Zero, Jr, HI, LO, DivByZero
  );

  // ALU side: accepts operations, produces results.
  modport slave (
    input  Start, ALUOperation, A, B,
    output Busy, Done, ALUResult, Zero, Jr, HI, LO, DivByZero
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : ALU with single-cycle logic/arith/shift ops plus iterative
//            unsigned shift-add MULT and restoring DIV (one bit per cycle).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  multicycle_alu_if.slave bus
);

  localparam int c_sw = $clog2(WIDTH);
  localparam int c_cw = $clog2(WIDTH) + 1;

  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_lui  = 4'b0010;
  localparam logic [3:0] c_op_add  = 4'b0011;
  localparam logic [3:0] c_op_sll  = 4'b0100;
  localparam logic [3:0] c_op_nor  = 4'b0101;
  localparam logic [3:0] c_op_srl  = 4'b0110;
  localparam logic [3:0] c_op_sub  = 4'b0111;
  localparam logic [3:0] c_op_jr   = 4'b1000;
  localparam logic [3:0] c_op_mult = 4'b1001;
  localparam logic [3:0] c_op_div  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Iteration working set: r_acc is the running HI half (partial product or
  // partial remainder), r_q the running LO half (multiplier bits / quotient).
  logic [c_cw-1:0]  r_count;
  logic             r_is_div;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_opnd;

  // Architecturally visible results, only written on entry to DONE.
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_jr;
  logic             r_dbz;

  logic             w_accept;
  logic             w_is_mult;
  logic             w_is_div;
  logic             w_b_zero;
  logic             w_go_busy;
  logic [c_sw-1:0]  w_shamt;
  logic [WIDTH-1:0] w_single;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_accept  = bus.Start && (r_state != S_BUSY);
  assign w_is_mult = (bus.ALUOperation == c_op_mult);
  assign w_is_div  = (bus.ALUOperation == c_op_div);
  assign w_b_zero  = (bus.B == '0);
  assign w_go_busy = w_is_mult || (w_is_div && !w_b_zero);
  assign w_shamt   = bus.B[c_sw-1:0];

  // Result of every operation that completes in the accepting cycle.
  always_comb begin
    w_single = '0;
    case (bus.ALUOperation)
      c_op_and: w_single = bus.A & bus.B;
      c_op_or:  w_single = bus.A | bus.B;
      c_op_lui: w_single = {bus.B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      c_op_add: w_single = bus.A + bus.B;
      c_op_sll: w_single = bus.A << w_shamt;
      c_op_nor: w_single = ~(bus.A | bus.B);
      c_op_srl: w_single = bus.A >> w_shamt;
      c_op_sub: w_single = bus.A - bus.B;
      c_op_jr:  w_single = bus.A;
      default:  w_single = '0;
    endcase
  end

  // One iteration step: shift-add for MULT, compare-subtract for DIV.
  always_comb begin
    w_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : '0);
    w_shift   = {r_acc, r_q[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_opnd});
    // Only used when w_ge holds, so the true difference fits in WIDTH bits.
    w_diff    = w_shift[WIDTH-1:0] - r_opnd;
    w_acc_nxt = w_sum[WIDTH:1];
    w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    if (r_is_div) begin
      w_acc_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], w_ge};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_nxt = w_go_busy ? S_BUSY : S_DONE;
        else          w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (r_count == c_cw'(1)) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_jr     <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_acc   <= w_acc_nxt;
      r_q     <= w_q_nxt;
      r_count <= r_count - c_cw'(1);
      if (r_count == c_cw'(1)) begin
        r_hi     <= w_acc_nxt;
        r_lo     <= w_q_nxt;
        r_result <= w_q_nxt;
        r_jr     <= 1'b0;
        if (r_is_div) r_dbz <= 1'b0;
      end
    end else if (w_accept) begin
      if (w_go_busy) begin
        r_is_div <= w_is_div;
        r_acc    <= '0;
        r_q      <= bus.A;
        r_opnd   <= bus.B;
        r_count  <= c_cw'(WIDTH);
      end else if (w_is_div) begin
        // Division by zero completes immediately with a saturated quotient.
        r_lo     <= '1;
        r_hi     <= bus.A;
        r_result <= '1;
        r_dbz    <= 1'b1;
        r_jr     <= 1'b0;
      end else begin
        r_result <= w_single;
        r_jr     <= (bus.ALUOperation == c_op_jr);
      end
    end
  end

  assign bus.Busy      = (r_state == S_BUSY);
  assign bus.Done      = (r_state == S_DONE);
  assign bus.ALUResult = r_result;
  assign bus.Zero      = (r_result == '0);
  assign bus.Jr        = r_jr;
  assign bus.HI        = r_hi;
  assign bus.LO        = r_lo;
  assign bus.DivByZero = r_dbz;

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width; legal values are even and at least 8.
REQ-002 The block SHALL have a single clock and reset: synchronous, active-low.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Start  input  1  request; accepted on an edge where Start=1 and Busy=0.
REQ-006 ALUOperation  input  4  opcode; sampled only at acceptance.
REQ-007 A, B  input  WIDTH each  operands; sampled only at acceptance.
REQ-008 Busy  output  1  high while a MULT or DIV is iterating.
REQ-009 Done  output  1  one-cycle pulse; marks new results valid.
REQ-010 ALUResult  output  WIDTH  registered result.
REQ-011 Zero  output  1  high when ALUResult equals 0.
REQ-012 Jr  output  1  high when the last accepted op was JR.
REQ-013 HI, LO  output  WIDTH each  product or remainder/quotient registers.
REQ-014 DivByZero  output  1  high when the last DIV had B=0.

Function
REQ-015 Opcodes SHALL be: AND=0000, OR=0001, LUI=0010, ADD=0011, SLL=0100, NOR=0101, SRL=0110, SUB=0111, JR=1000, MULT=1001, DIV=1010; all others are undefined.
REQ-016 Single-cycle ops SHALL be: ADD A+B mod 2^WIDTH; SUB A-B mod 2^WIDTH; AND; OR; NOR; LUI {B[WIDTH/2-1:0], WIDTH/2 zeros}; SLL A<<B; SRL A>>B (logical, shift amount = B[$clog2(WIDTH)-1:0]); JR ALUResult=A; undefined opcodes ALUResult=0.
REQ-017 States SHALL be IDLE, BUSY, DONE; Done=1 only in DONE; Busy=1 only in BUSY.
REQ-018 Transitions: IDLE/DONE + accepted single-cycle op or DIV-by-zero -> DONE; IDLE/DONE + accepted MULT or DIV with B!=0 -> BUSY, iteration count=WIDTH; BUSY -> BUSY while count>1, decrementing each edge; BUSY with count=1 -> DONE; DONE without Start -> IDLE.
REQ-019 Latency SHALL be: single-cycle op -> Done high in the cycle after the accepting edge; MULT/DIV -> Done high after exactly WIDTH+1 edges.
REQ-020 Start SHALL be accepted in DONE, giving back-to-back operation with no idle cycle.
REQ-021 Start while Busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 MULT SHALL compute an unsigned shift-add product of 2*WIDTH bits, one bit per BUSY cycle: HI=upper half, LO=lower half, ALUResult=LO.
REQ-023 DIV SHALL be unsigned restoring division, one bit per BUSY cycle: LO=quotient, HI=remainder, ALUResult=LO.
REQ-024 DIV with B=0 SHALL skip BUSY and complete as a single-cycle op: LO=all ones, HI=A, ALUResult=all ones, DivByZero=1.
REQ-025 HI/LO SHALL update only on MULT/DIV completion and SHALL hold through other ops.
REQ-026 DivByZero SHALL update only on DIV completion.
REQ-027 ALUResult, Zero and Jr SHALL update only on entry to DONE and SHALL hold until the next completion.
REQ-028 Intermediate values SHALL NOT appear on outputs while Busy=1.

Reset
REQ-029 reset=0 at any edge, including mid-iteration, SHALL force IDLE, abandon the operation, and clear Busy, Done, ALUResult, HI, LO, Jr and DivByZero to 0; Zero SHALL be 1.
REQ-030 Start SHALL be ignored on an edge where reset=0.
REQ-031 The first accepted Start after reset release SHALL behave normally.

Verification
REQ-032 WIDTH=32, ADD A=0xFFFFFFFF, B=1 -> one cycle later Done=1, ALUResult=0, Zero=1.
REQ-033 LUI B=0x00001234 -> ALUResult=0x12340000; then JR A=0x00400020 -> ALUResult=0x00400020, Jr=1.
REQ-034 MULT A=0xFFFFFFFF, B=2 -> Busy for 32 cycles, Done on edge 33, HI=1, LO=0xFFFFFFFE; Start pulsed mid-Busy is ignored.
REQ-035 DIV A=100, B=7 -> LO=14, HI=2 after 33 edges; then DIV A=5, B=0 -> one cycle later DivByZero=1, LO=0xFFFFFFFF, HI=5.
REQ-036 reset=0 at BUSY cycle 10 of a MULT -> next cycle IDLE, all outputs 0, Zero=1, Done never pulses.
REQ-037 Start held high across DONE with SUB 5-7 -> back-to-back completions, second ALUResult=0xFFFFFFFE.
